// File: rtl/opl_timer_bank.sv
// OPL-style timer bank: up to four 8-bit up-counting timers behind a two-bank
// index/data register port, with status flags, interrupt and a poll-storm detector.
module opl_timer_bank #(
    parameter int          NUM_TIMERS  = 2,
    parameter logic [35:0] RESOLUTION  = {9'd319, 9'd319, 9'd319, 9'd79},
    parameter int          POLL_LIMIT  = 20,
    parameter int          POLL_WINDOW = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_1us,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       we,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       irq_n
);
    localparam logic [5:0]  LIMIT     = 6'(POLL_LIMIT);
    localparam logic [16:0] WINDOW    = 17'(POLL_WINDOW);
    localparam bit          HAS_BANK1 = (NUM_TIMERS > 2);

    logic        we_q, we_d, rd_q, rd_d;
    logic        we_armed_q, we_armed_d;
    logic [8:0]  index_q, index_d;
    logic [5:0]  rdcnt_q, rdcnt_d;
    logic [16:0] us_q, us_d;
    logic        force_q, force_d;
    logic        wr_ev, rd_ev, data_wr, ctrl_any;
    logic [3:0]  flag;
    logic [1:0]  bank_flags;

    always_comb begin
        // we_armed blocks a write event until we has been seen low after reset
        wr_ev      = we & ~we_q & we_armed_q;
        rd_ev      = rd & ~rd_q;
        data_wr    = wr_ev & addr[0];
        ctrl_any   = data_wr && ((index_q == 9'h004) || (HAS_BANK1 && index_q == 9'h104));
        we_d       = we;
        rd_d       = rd;
        we_armed_d = we_armed_q | ~we;
        index_d    = index_q;
        if (wr_ev && !addr[0]) begin
            index_d = {addr[1], din};
        end

        rdcnt_d = rdcnt_q;
        us_d    = us_q;
        force_d = 1'b0;
        if (rd_ev) begin
            us_d    = '0;
            force_d = (rdcnt_q == LIMIT);
            if (rdcnt_q != 6'h3F) begin
                rdcnt_d = rdcnt_q + 6'd1;
            end
        end else if (us_q >= WINDOW || ctrl_any) begin
            rdcnt_d = '0;
            us_d    = '0;
        end else if (ce_1us && us_q != 17'h1FFFF) begin
            us_d = us_q + 17'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            we_armed_q <= ~we;
            index_q    <= '0;
            rdcnt_q    <= '0;
            us_q       <= '0;
            force_q    <= 1'b0;
        end else begin
            we_q       <= we_d;
            rd_q       <= rd_d;
            we_armed_q <= we_armed_d;
            index_q    <= index_d;
            rdcnt_q    <= rdcnt_d;
            us_q       <= us_d;
            force_q    <= force_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_timer
        if (gi < NUM_TIMERS) begin : g_on
            localparam int         BANK       = gi / 2;
            localparam int         SLOT       = gi % 2;
            localparam logic [8:0] PRESET_IDX = 9'(BANK * 256 + 2 + SLOT);
            localparam logic [8:0] CTRL_IDX   = 9'(BANK * 256 + 4);
            localparam logic [8:0] RES        = RESOLUTION[9*gi +: 9];

            logic [7:0] preset_q, preset_d, counter_q, counter_d;
            logic [8:0] sub_q, sub_d;
            logic       mask_q, mask_d, start_q, start_d, start_dly_q, start_dly_d;
            logic       ovf_q, ovf_d, flag_q, flag_d;
            logic       ctrl_wr;

            always_comb begin
                ctrl_wr     = data_wr && (index_q == CTRL_IDX);
                preset_d    = preset_q;
                mask_d      = mask_q;
                start_d     = start_q;
                start_dly_d = start_q;
                counter_d   = counter_q;
                sub_d       = sub_q;
                ovf_d       = 1'b0;
                flag_d      = flag_q;

                if (data_wr && index_q == PRESET_IDX) begin
                    preset_d = din;
                end
                if (ctrl_wr && !din[7]) begin
                    mask_d  = (SLOT == 0) ? din[6] : din[5];
                    start_d = (SLOT == 0) ? din[0] : din[1];
                end

                // The cycle after start rises is spent loading; its ce_1us is dropped.
                if (start_q && !start_dly_q) begin
                    counter_d = preset_q;
                    sub_d     = RES;
                end else if (start_q && ce_1us) begin
                    if (sub_q != 9'd0) begin
                        sub_d = sub_q - 9'd1;
                    end else begin
                        sub_d = RES;
                        if (counter_q == 8'hFF) begin
                            counter_d = preset_q;
                            ovf_d     = 1'b1;
                        end else begin
                            counter_d = counter_q + 8'd1;
                        end
                    end
                end

                if (ctrl_wr && din[7]) begin
                    flag_d = 1'b0;
                end
                if ((ovf_q || force_q) && !mask_q) begin
                    flag_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    preset_q    <= '0;
                    mask_q      <= 1'b0;
                    start_q     <= 1'b0;
                    start_dly_q <= 1'b0;
                    counter_q   <= '0;
                    sub_q       <= '0;
                    ovf_q       <= 1'b0;
                    flag_q      <= 1'b0;
                end else begin
                    preset_q    <= preset_d;
                    mask_q      <= mask_d;
                    start_q     <= start_d;
                    start_dly_q <= start_dly_d;
                    counter_q   <= counter_d;
                    sub_q       <= sub_d;
                    ovf_q       <= ovf_d;
                    flag_q      <= flag_d;
                end
            end

            assign flag[gi] = flag_q;
        end else begin : g_off
            assign flag[gi] = 1'b0;
        end
    end

    assign bank_flags = addr[1] ? flag[3:2] : flag[1:0];
    assign dout       = {bank_flags[0] | bank_flags[1], bank_flags[0], bank_flags[1], 5'b0};
    assign irq_n      = ~|flag;

endmodule

// File: tb/tb_opl_timer_bank.sv
// Bench for opl_timer_bank: a 2-timer and a 4-timer instance share one bus and are
// compared against a pulse-counting reference model of timers, flags and poll detector.
module tb_opl_timer_bank;
    localparam int W   = 500;
    localparam int LIM = 20;

    logic       clk = 1'b0;
    logic       reset, ce_1us, we, rd;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout2, dout4;
    logic       irq2_n, irq4_n;

    opl_timer_bank #(.NUM_TIMERS(2), .POLL_WINDOW(W)) dut2 (
        .clk(clk), .reset(reset), .ce_1us(ce_1us), .addr(addr), .din(din),
        .we(we), .rd(rd), .dout(dout2), .irq_n(irq2_n));

    opl_timer_bank #(.NUM_TIMERS(4), .POLL_WINDOW(W)) dut4 (
        .clk(clk), .reset(reset), .ce_1us(ce_1us), .addr(addr), .din(din),
        .we(we), .rd(rd), .dout(dout4), .irq_n(irq4_n));

    always #5 clk = ~clk;

    // Reference model: each running timer counts ce_1us pulses down to its next overflow.
    int nt [2] = '{2, 4};
    int unit [4] = '{80, 320, 320, 320};
    bit m_flag [2][4];
    bit m_mask [2][4];
    bit m_start [2][4];
    int m_preset [2][4];
    int m_left [2][4];
    int m_rdcnt [2];
    int m_us [2];
    int m_index;
    int n_checks = 0;
    int n_fail = 0;

    function automatic void model_reset();
        m_index = 0;
        for (int i = 0; i < 2; i++) begin
            m_rdcnt[i] = 0;
            m_us[i] = 0;
            for (int k = 0; k < 4; k++) begin
                m_flag[i][k] = 0; m_mask[i][k] = 0; m_start[i][k] = 0;
                m_preset[i][k] = 0; m_left[i][k] = 0;
            end
        end
    endfunction

    function automatic void model_set_all(int i);
        for (int k = 0; k < nt[i]; k++) begin
            if (!m_mask[i][k]) m_flag[i][k] = 1;
        end
    endfunction

    function automatic void model_data_write(int idx, logic [7:0] d);
        int b;
        int s;
        bit ns;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < nt[i]; k++) begin
                b = k / 2;
                s = k % 2;
                if (idx == b * 256 + 2 + s) m_preset[i][k] = int'(d);
                if (idx == b * 256 + 4) begin
                    if (d[7]) begin
                        m_flag[i][k] = 0;
                    end else begin
                        ns = (s == 0) ? d[0] : d[1];
                        if (ns && !m_start[i][k]) m_left[i][k] = unit[k] * (256 - m_preset[i][k]);
                        m_start[i][k] = ns;
                        m_mask[i][k] = (s == 0) ? d[6] : d[5];
                    end
                end
            end
            if (idx == 9'h004 || (idx == 9'h104 && nt[i] > 2)) begin
                m_rdcnt[i] = 0;
                m_us[i] = 0;
            end
        end
    endfunction

    function automatic void model_pulse();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < nt[i]; k++) begin
                if (m_start[i][k]) begin
                    m_left[i][k]--;
                    if (m_left[i][k] == 0) begin
                        if (!m_mask[i][k]) m_flag[i][k] = 1;
                        m_left[i][k] = unit[k] * (256 - m_preset[i][k]);
                    end
                end
            end
            m_us[i]++;
            if (m_us[i] >= W) begin
                m_rdcnt[i] = 0;
                m_us[i] = 0;
            end
        end
    endfunction

    function automatic void model_read();
        for (int i = 0; i < 2; i++) begin
            if (m_rdcnt[i] == LIM) model_set_all(i);
            if (m_rdcnt[i] != 63) m_rdcnt[i]++;
            m_us[i] = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; din = d; we = 1'b1;
        step();
        we = 1'b0;
        step();
        if (!a[0]) m_index = int'({a[1], d});
        else model_data_write(m_index, d);
    endtask

    task automatic write_reg(input int idx, input logic [7:0] d);
        logic [8:0] ix;
        ix = 9'(idx);
        bus_write({ix[8], 1'b0}, ix[7:0]);
        bus_write({ix[8], 1'b1}, d);
        $display("write idx=%03h data=%02h", ix, d);
    endtask

    task automatic pulses(input int n);
        for (int p = 0; p < n; p++) begin
            ce_1us = 1'b1;
            step();
            ce_1us = 1'b0;
            step();
            model_pulse();
        end
        $display("pulses n=%0d", n);
    endtask

    task automatic read_event();
        rd = 1'b1;
        step();
        rd = 1'b0;
        step();
        model_read();
        $display("read event");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        model_reset();
        $display("reset pulse");
    endtask

    task automatic check(input string tag);
        logic [7:0] obs_v;
        logic [7:0] exp_v;
        logic       obs_i;
        logic       exp_i;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 2; b++) begin
                addr = {b[0], 1'b0};
                #1;
                obs_v = (i == 0) ? dout2 : dout4;
                exp_v = {m_flag[i][2*b] | m_flag[i][2*b+1], m_flag[i][2*b], m_flag[i][2*b+1], 5'b0};
                n_checks++;
                assert (obs_v === exp_v) else begin
                    n_fail++;
                    $error("FAIL %s dout nt=%0d bank%0d observed=%02h expected=%02h", tag, nt[i], b, obs_v, exp_v);
                end
            end
            obs_i = (i == 0) ? irq2_n : irq4_n;
            exp_i = ~(m_flag[i][0] | m_flag[i][1] | m_flag[i][2] | m_flag[i][3]);
            n_checks++;
            assert (obs_i === exp_i) else begin
                n_fail++;
                $error("FAIL %s irq_n nt=%0d observed=%b expected=%b", tag, nt[i], obs_i, exp_i);
            end
        end
    endtask

    initial begin
        int op;
        int k;
        int b;
        logic [7:0] d;

        // we held high across reset release must not become a write event
        reset = 1'b1; ce_1us = 1'b0; rd = 1'b0; addr = 2'b00; din = 8'h04; we = 1'b1;
        model_reset();
        repeat (3) step();
        check("reset_state");
        addr = 2'b00; din = 8'h04;
        reset = 1'b0;
        repeat (3) step();
        we = 1'b0;
        step();
        bus_write(2'b01, 8'h01);

        // Timer0: preset FE, 160-pulse period
        write_reg(9'h002, 8'hFE);
        write_reg(9'h004, 8'h01);
        pulses(159);
        check("ovf_minus_one");
        pulses(1);
        check("ovf_first");

        // Clear keeps timer running
        write_reg(9'h004, 8'h80);
        check("flag_clear");
        pulses(159);
        check("second_minus_one");
        pulses(1);
        check("ovf_second");

        // Timer3 in bank 1 (absent on the 2-timer instance)
        write_reg(9'h004, 8'h00);
        write_reg(9'h004, 8'h80);
        write_reg(9'h103, 8'hFF);
        write_reg(9'h104, 8'h02);
        pulses(319);
        check("timer3_minus_one");
        pulses(1);
        check("timer3_ovf");

        // Poll-storm forced overflow with timer1 masked
        write_reg(9'h004, 8'h20);
        for (int r = 0; r < 20; r++) begin
            read_event();
            pulses(int'($urandom_range(1, 40)));
        end
        check("poll_20_reads");
        read_event();
        check("poll_force");
        read_event();
        check("poll_after_force");

        // Poll window expiry and its boundary
        do_reset();
        repeat (20) read_event();
        pulses(W);
        read_event();
        check("poll_window_expired");
        repeat (19) read_event();
        pulses(W - 1);
        read_event();
        check("poll_window_edge");

        // Reset landing on the overflow pulse
        do_reset();
        write_reg(9'h002, 8'hFE);
        write_reg(9'h004, 8'h01);
        pulses(159);
        ce_1us = 1'b1;
        reset = 1'b1;
        step();
        ce_1us = 1'b0;
        step();
        reset = 1'b0;
        step();
        model_reset();
        $display("reset at overflow");
        check("reset_at_ovf");
        pulses(200);
        check("no_count_after_reset");
        write_reg(9'h002, 8'hFF);
        write_reg(9'h004, 8'h01);
        pulses(79);
        check("restart_minus_one");
        pulses(1);
        check("restart_ovf");

        // Randomized register/pulse/read traffic
        do_reset();
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    k = int'($urandom_range(0, 3));
                    write_reg((k / 2) * 256 + 2 + (k % 2), 8'($urandom_range(252, 255)));
                end
                1: begin
                    b = int'($urandom_range(0, 1));
                    d = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom & 32'h63);
                    write_reg(b * 256 + 4, d);
                end
                2: pulses(int'($urandom_range(1, 150)));
                3: repeat ($urandom_range(1, 6)) read_event();
                default: write_reg(int'($urandom_range(5, 255)) + 256 * int'($urandom_range(0, 1)),
                                   8'($urandom));
            endcase
            check("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
